// File: rtl/screen_sequencer.sv
// Screen controller for the runner game: sequences MENU/PLAY/OVER on frame
// boundaries, gates the game logic and selects which renderer drives RGB.
module screen_sequencer #(
  parameter int H_ACTIVE         = 640,
  parameter int V_ACTIVE         = 480,
  parameter int DEBOUNCE_CYCLES  = 16,
  parameter int OVER_HOLD_FRAMES = 60
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] Hcount,
  input  logic [15:0] Vcount,
  input  logic        btn_start,
  input  logic        collision,
  input  logic [11:0] menu_rgb,
  input  logic [11:0] play_rgb,
  input  logic [11:0] over_rgb,
  output logic [3:0]  r_red,
  output logic [3:0]  r_green,
  output logic [3:0]  r_blue,
  output logic        game_run,
  output logic        game_reset,
  output logic [1:0]  state
);

  localparam int              CNT_W     = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [15:0]     H_LIM     = 16'(H_ACTIVE);
  localparam logic [15:0]     V_LIM     = 16'(V_ACTIVE);
  localparam logic [7:0]      HOLD_INIT = 8'(OVER_HOLD_FRAMES);

  localparam logic [1:0] S_MENU = 2'd0;
  localparam logic [1:0] S_PLAY = 2'd1;
  localparam logic [1:0] S_OVER = 2'd2;

  function automatic logic [7:0] sat_dec(input logic [7:0] v);
    return (v == 8'd0) ? 8'd0 : v - 8'd1;
  endfunction

  function automatic logic [11:0] blank_px(input logic [15:0] h, input logic [15:0] v,
                                           input logic [11:0] px);
    return ((h >= H_LIM) || (v >= V_LIM)) ? 12'd0 : px;
  endfunction

  logic             sync1, sync2, stable, stable_d;
  logic [CNT_W-1:0] db_cnt;
  logic             start_evt, frame_tick, start_ok, over_ok;
  logic             start_pend, over_pend;
  logic [1:0]       state_q, state_d;
  logic [7:0]       hold_q, hold_d;
  logic             run_d, reset_d;
  logic [11:0]      src_rgb, rgb_p1;

  // Button synchroniser and debouncer: stable follows sync2 only after
  // DEBOUNCE_CYCLES consecutive disagreeing samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1    <= 1'b0;
      sync2    <= 1'b0;
      stable   <= 1'b0;
      stable_d <= 1'b0;
      db_cnt   <= '0;
    end else begin
      sync1    <= btn_start;
      sync2    <= sync1;
      stable_d <= stable;
      if (sync2 == stable) begin
        db_cnt <= '0;
      end else if (db_cnt == CNT_LAST) begin
        stable <= sync2;
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end
  end

  assign start_evt  = stable & ~stable_d;
  assign frame_tick = (Hcount == 16'd0) && (Vcount == V_LIM);
  assign start_ok   = start_evt && ((state_q == S_MENU) ||
                                    ((state_q == S_OVER) && (hold_q == 8'd0)));
  assign over_ok    = collision && (state_q == S_PLAY);

  // Requests wait here for the next frame boundary.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_pend <= 1'b0;
      over_pend  <= 1'b0;
    end else if (frame_tick) begin
      start_pend <= 1'b0;
      over_pend  <= 1'b0;
    end else begin
      start_pend <= start_pend | start_ok;
      over_pend  <= over_pend | over_ok;
    end
  end

  // ---- FSM state register (p0 -> p1 boundary) ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_MENU;
      hold_q     <= 8'd0;
      game_run   <= 1'b0;
      game_reset <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_q     <= hold_d;
      game_run   <= run_d;
      game_reset <= reset_d;
    end
  end

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    case (state_q)
      S_MENU: if (frame_tick && (start_pend || start_ok)) state_d = S_PLAY;
      S_PLAY: if (frame_tick && (over_pend || over_ok)) begin
        state_d = S_OVER;
        hold_d  = HOLD_INIT;
      end
      S_OVER: if (frame_tick) begin
        if (hold_q != 8'd0)               hold_d  = sat_dec(hold_q);
        else if (start_pend || start_ok)  state_d = S_MENU;
      end
      default: state_d = S_MENU;
    endcase
  end

  always_comb begin
    run_d   = (state_d == S_PLAY);
    reset_d = (state_q == S_MENU) && (state_d == S_PLAY);
  end

  always_comb begin
    case (state_q)
      S_PLAY:  src_rgb = play_rgb;
      S_OVER:  src_rgb = over_rgb;
      default: src_rgb = menu_rgb;
    endcase
  end

  // ---- pixel mux register (p0 -> p1 boundary) ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rgb_p1 <= 12'd0;
    else        rgb_p1 <= blank_px(Hcount, Vcount, src_rgb);
  end

  assign {r_red, r_green, r_blue} = rgb_p1;
  assign state = state_q;

endmodule

// File: tb/tb_screen_sequencer.sv
// Directed bench for screen_sequencer with a frame-level reference model.
module tb_screen_sequencer;
  localparam int H_ACT = 640;
  localparam int V_ACT = 480;
  localparam int DEB   = 4;
  localparam int HOLD  = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] Hcount, Vcount;
  logic        btn_start, collision;
  logic [11:0] menu_rgb, play_rgb, over_rgb;
  logic [3:0]  r_red, r_green, r_blue;
  logic        game_run, game_reset;
  logic [1:0]  state;

  screen_sequencer #(
    .H_ACTIVE(H_ACT), .V_ACTIVE(V_ACT),
    .DEBOUNCE_CYCLES(DEB), .OVER_HOLD_FRAMES(HOLD)
  ) dut (
    .clk(clk), .rst_n(rst_n), .Hcount(Hcount), .Vcount(Vcount),
    .btn_start(btn_start), .collision(collision),
    .menu_rgb(menu_rgb), .play_rgb(play_rgb), .over_rgb(over_rgb),
    .r_red(r_red), .r_green(r_green), .r_blue(r_blue),
    .game_run(game_run), .game_reset(game_reset), .state(state)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: screen (0 menu, 1 play, 2 over), pending requests,
  // remaining hold frames, and the button history seen by the debouncer.
  typedef struct {
    logic [1:0]  st;
    logic        run;
    logic        rst_p;
    int          hold;
    logic        spend;
    logic        opend;
    logic        stab;
    logic        evt;
    logic [31:0] bh;
    logic [11:0] rgb;
  } mdl_t;

  function automatic mdl_t mdl_rst();
    mdl_t r;
    r.st = 2'd0; r.run = 1'b0; r.rst_p = 1'b0; r.hold = 0;
    r.spend = 1'b0; r.opend = 1'b0; r.stab = 1'b0; r.evt = 1'b0;
    r.bh = 32'd0; r.rgb = 12'd0;
    return r;
  endfunction

  function automatic mdl_t nxt(input mdl_t m, input logic b, input logic c,
                               input logic [15:0] h, input logic [15:0] v,
                               input logic [11:0] mr, input logic [11:0] pr,
                               input logic [11:0] orr);
    mdl_t n;
    bit tick, st_ok, ov_ok, flip;
    n = m;
    tick  = (h == 16'd0) && (v == 16'(V_ACT));
    st_ok = m.evt && ((m.st == 2'd0) || ((m.st == 2'd2) && (m.hold == 0)));
    ov_ok = c && (m.st == 2'd1);
    n.rst_p = 1'b0;
    if (m.st == 2'd0) begin
      if (tick && (m.spend || st_ok)) begin n.st = 2'd1; n.rst_p = 1'b1; end
    end else if (m.st == 2'd1) begin
      if (tick && (m.opend || ov_ok)) begin n.st = 2'd2; n.hold = HOLD; end
    end else if (m.st == 2'd2) begin
      if (tick) begin
        if (m.hold > 0) n.hold = m.hold - 1;
        else if (m.spend || st_ok) n.st = 2'd0;
      end
    end else begin
      n.st = 2'd0;
    end
    n.spend = tick ? 1'b0 : (m.spend | st_ok);
    n.opend = tick ? 1'b0 : (m.opend | ov_ok);
    n.run   = (n.st == 2'd1);
    if ((h >= 16'(H_ACT)) || (v >= 16'(V_ACT))) n.rgb = 12'd0;
    else if (m.st == 2'd1) n.rgb = pr;
    else if (m.st == 2'd2) n.rgb = orr;
    else n.rgb = mr;
    // The debounced level flips once the last DEB synchronised samples all disagree with it.
    flip = 1'b1;
    for (int j = 1; j <= DEB; j++) if (m.bh[j] == m.stab) flip = 1'b0;
    n.stab = flip ? ~m.stab : m.stab;
    n.evt  = flip && !m.stab;
    n.bh   = {m.bh[30:0], b};
    return n;
  endfunction

  mdl_t m;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m <= mdl_rst();
    else        m <= nxt(m, btn_start, collision, Hcount, Vcount, menu_rgb, play_rgb, over_rgb);
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("state", 32'(state), 32'(m.st));
      chk("game_run", 32'(game_run), 32'(m.run));
      chk("game_reset", 32'(game_reset), 32'(m.rst_p));
      chk("rgb", 32'({r_red, r_green, r_blue}), 32'(m.rgb));
    end
  end

  task automatic step(input logic [15:0] h, input logic [15:0] v);
    Hcount = h;
    Vcount = v;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step(16'd100, 16'd100);
  endtask

  task automatic press();
    btn_start = 1'b1;
    idle(DEB + 4);
    btn_start = 1'b0;
    idle(DEB + 4);
  endtask

  task automatic tick();
    step(16'd0, 16'(V_ACT));
  endtask

  initial begin
    rst_n = 1'b0; btn_start = 1'b0; collision = 1'b0;
    Hcount = 16'd100; Vcount = 16'd100;
    menu_rgb = 12'h123; play_rgb = 12'h456; over_rgb = 12'h789;
    idle(3);
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_rgb", 32'({r_red, r_green, r_blue}), 32'd0);
    chk("rst_run", 32'(game_run), 32'd0);
    cmp_en = 1'b1;
    rst_n = 1'b1;
    step(16'd100, 16'd100);
    chk("menu_pixel", 32'({r_red, r_green, r_blue}), 32'h123);

    // a pulse one sample short of the debounce window never registers
    btn_start = 1'b1; idle(DEB - 1);
    btn_start = 1'b0; idle(8);
    tick();
    chk("short_pulse_ignored", 32'(state), 32'd0);

    // bounce then hold: exactly one start, applied at the next frame tick
    btn_start = 1'b1; idle(2);
    btn_start = 1'b0; idle(2);
    btn_start = 1'b1; idle(10);
    chk("wait_for_tick", 32'(state), 32'd0);
    tick();
    chk("enter_play", 32'(state), 32'd1);
    chk("game_reset_pulse", 32'(game_reset), 32'd1);
    chk("game_run_rise", 32'(game_run), 32'd1);
    step(16'd100, 16'd100);
    chk("game_reset_drop", 32'(game_reset), 32'd0);
    chk("play_pixel", 32'({r_red, r_green, r_blue}), 32'h456);
    btn_start = 1'b0; idle(8);

    // collision and start together mid-frame: collision wins at the tick
    collision = 1'b1; btn_start = 1'b1;
    step(16'd100, 16'd200);
    collision = 1'b0;
    idle(10);
    btn_start = 1'b0; idle(8);
    chk("hold_play_until_tick", 32'(state), 32'd1);
    tick();
    chk("enter_over", 32'(state), 32'd2);
    chk("over_run_low", 32'(game_run), 32'd0);
    step(16'd100, 16'd100);
    chk("over_pixel", 32'({r_red, r_green, r_blue}), 32'h789);

    // OVER ignores start for HOLD frames
    press(); tick();
    chk("over_hold_frame1", 32'(state), 32'd2);
    press(); tick();
    chk("over_hold_frame2", 32'(state), 32'd2);
    press(); tick();
    chk("over_exit", 32'(state), 32'd0);
    step(16'd100, 16'd100);
    chk("menu_again_pixel", 32'({r_red, r_green, r_blue}), 32'h123);

    // blanking boundaries
    menu_rgb = 12'hFFF; play_rgb = 12'hFFF; over_rgb = 12'hFFF;
    step(16'd640, 16'd10);
    chk("blank_h640", 32'({r_red, r_green, r_blue}), 32'd0);
    step(16'd10, 16'd480);
    chk("blank_v480", 32'({r_red, r_green, r_blue}), 32'd0);
    step(16'd639, 16'd479);
    chk("last_visible", 32'({r_red, r_green, r_blue}), 32'hFFF);
    step(16'hFFFF, 16'd0);
    chk("blank_hmax", 32'({r_red, r_green, r_blue}), 32'd0);

    // asynchronous reset mid-line while in PLAY
    press(); tick();
    chk("play_before_reset", 32'(state), 32'd1);
    step(16'd100, 16'd50);
    rst_n = 1'b0;
    #1;
    chk("async_rst_state", 32'(state), 32'd0);
    chk("async_rst_run", 32'(game_run), 32'd0);
    chk("async_rst_rgb", 32'({r_red, r_green, r_blue}), 32'd0);
    step(16'd100, 16'd100);
    rst_n = 1'b1;
    step(16'd100, 16'd100);
    chk("post_rst_menu", 32'({r_red, r_green, r_blue}), 32'hFFF);
    chk("post_rst_state", 32'(state), 32'd0);

    // illegal state recovers to MENU on the next clock
    menu_rgb = 12'h123; play_rgb = 12'h456; over_rgb = 12'h789;
    idle(1);
    cmp_en = 1'b0;
    force dut.state_q = 2'd3;
    step(16'd100, 16'd100);
    chk("illegal_rgb_menu", 32'({r_red, r_green, r_blue}), 32'h123);
    chk("illegal_run_low", 32'(game_run), 32'd0);
    release dut.state_q;
    step(16'd100, 16'd100);
    chk("illegal_recover", 32'(state), 32'd0);
    cmp_en = 1'b1;
    idle(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
